// File: rtl/aes_pkg.sv
// Shared constants and GF(2^8) helpers for the AES round datapath.
// Byte k of a 128-bit state lives at bits [127-8k -: 8].
package aes_pkg;

  localparam logic [1:0] MODE_INITIAL = 2'd0;
  localparam logic [1:0] MODE_MIDDLE  = 2'd1;
  localparam logic [1:0] MODE_FINAL   = 2'd2;

  function automatic logic [7:0] xtime(
    input logic [7:0] x
  );
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic int byte_hi(input int k);
    return 127 - 8 * k;
  endfunction

  function automatic int byte_idx(
    input int r,
    input int c
  );
    return 4 * c + r;
  endfunction

endpackage

// File: rtl/aes_round_datapath_if.sv
// Round datapath transaction bundle: state, key and
// mode in, transformed state out.
interface aes_round_datapath_if;
  logic         i_valid;
  logic [1:0]   i_mode;
  logic [127:0] i_state;
  logic [127:0] i_key;
  logic         o_valid;
  logic [127:0] o_state;

  modport master (
    output i_valid,
    output i_mode,
    output i_state,
    output i_key,
    input  o_valid,
    input  o_state
  );

  modport slave (
    input  i_valid,
    input  i_mode,
    input  i_state,
    input  i_key,
    output o_valid,
    output o_state
  );
endinterface

// File: rtl/aes_mix_column.sv
// MixColumns on one 32-bit column; a0 is the top byte.
// Fixed matrix rows 2-3-1-1 rotated per output byte.
import aes_pkg::*;

module aes_mix_column (
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_a0, w_a1, w_a2, w_a3;
  logic [7:0] w_x0, w_x1, w_x2, w_x3;

  assign w_a0 = i_col[31:24];
  assign w_a1 = i_col[23:16];
  assign w_a2 = i_col[15:8];
  assign w_a3 = i_col[7:0];

  assign w_x0 = xtime(w_a0);
  assign w_x1 = xtime(w_a1);
  assign w_x2 = xtime(w_a2);
  assign w_x3 = xtime(w_a3);

  // 3x is folded in as xtime(x)^x
  assign o_col[31:24] =
    w_x0 ^ w_x1 ^ w_a1 ^ w_a2 ^ w_a3;
  assign o_col[23:16] =
    w_a0 ^ w_x1 ^ w_x2 ^ w_a2 ^ w_a3;
  assign o_col[15:8] =
    w_a0 ^ w_a1 ^ w_x2 ^ w_x3 ^ w_a3;
  assign o_col[7:0] =
    w_x0 ^ w_a0 ^ w_a1 ^ w_a2 ^ w_x3;

endmodule

// File: rtl/aes_round_datapath.sv
// One AES encryption round minus SubBytes: ShiftRows,
// MixColumns and AddRoundKey selected by mode.
import aes_pkg::*;

module aes_round_datapath #(
  parameter bit OUT_REG = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  aes_round_datapath_if.slave bus
);

  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_res;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = byte_hi(byte_idx(r, c));
      localparam int SRC =
        byte_hi(byte_idx(r, (c + r) % 4));
      assign w_sr[DST -: 8] = bus.i_state[SRC -: 8];
    end

    aes_mix_column u_mc (
      .i_col (w_sr[127-32*c -: 32]),
      .o_col (w_mc[127-32*c -: 32])
    );
  end

  // reserved mode 3 falls through to the FINAL path
  always_comb begin
    w_res = w_sr ^ bus.i_key;
    unique case (bus.i_mode)
      MODE_INITIAL: w_res = bus.i_state ^ bus.i_key;
      MODE_MIDDLE:  w_res = w_mc ^ bus.i_key;
      default:      w_res = w_sr ^ bus.i_key;
    endcase
  end

  if (OUT_REG) begin : g_reg
    logic         r_valid;
    logic [127:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_state <= '0;
      end else begin
        r_valid <= bus.i_valid;
        if (bus.i_valid) r_state <= w_res;
      end
    end

    assign bus.o_valid = r_valid;
    assign bus.o_state = r_state;
  end else begin : g_comb
    assign bus.o_valid = bus.i_valid;
    assign bus.o_state = w_res;
  end

endmodule

// File: tb/tb_aes_round_datapath.sv
// Directed bench for aes_round_datapath: FIPS-197 round
// vectors, per-column MixColumns, streaming and reset.
module tb_aes_round_datapath;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [127:0] q[$];
  logic [127:0] last_exp;

  aes_round_datapath_if bus ();

  aes_round_datapath #(.OUT_REG(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk1(
    input string tag,
    input logic  got,
    input logic  exp
  );
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b",
             tag, got, exp);
    end
  endtask

  task automatic chk128(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, got, exp);
    end
  endtask

  // Put column a into target column c pre-inverse-ShiftRows,
  // so after ShiftRows it lands whole in column c.
  function automatic logic [127:0] place_col(
    input logic [31:0] a,
    input int          c
  );
    logic [127:0] s;
    s = '0;
    for (int r = 0; r < 4; r++)
      s[127 - 8*(4*((c + r) % 4) + r) -: 8] =
        a[31 - 8*r -: 8];
    return s;
  endfunction

  function automatic logic [127:0] out_col(
    input logic [31:0] b,
    input int          c
  );
    logic [127:0] s;
    s = '0;
    s[127 - 32*c -: 32] = b;
    return s;
  endfunction

  // Drive at negedge, check the result just after posedge.
  task automatic step(
    input string        tag,
    input logic         v,
    input logic [1:0]   m,
    input logic [127:0] s,
    input logic [127:0] k,
    input logic [127:0] e
  );
    logic [127:0] exp;
    @(negedge clk);
    bus.i_valid = v;
    bus.i_mode  = m;
    bus.i_state = s;
    bus.i_key   = k;
    if (v) q.push_back(e);
    @(posedge clk);
    #1;
    chk1({tag, "_valid"}, bus.o_valid, v);
    if (bus.o_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s: unexpected output %h",
               tag, bus.o_state);
      end else begin
        exp = q.pop_front();
        last_exp = exp;
        chk128({tag, "_state"}, bus.o_state, exp);
      end
    end else begin
      chk128({tag, "_hold"}, bus.o_state, last_exp);
    end
  endtask

  initial begin
    logic [127:0] s_fin;
    logic [127:0] e_fin;
    logic [127:0] s_ini, k_ini, e_ini;
    logic [127:0] s_mid, k_mid, e_mid;

    s_ini = 128'h3243f6a8885a308d313198a2e0370734;
    k_ini = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    e_ini = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    s_mid = 128'hd42711aee0bf98f1b8b45de51e415230;
    k_mid = 128'ha0fafe1788542cb123a339392a6c7605;
    e_mid = 128'ha49c7ff2689f352b6b5bea43026a5049;
    s_fin = 128'h000102030405060708090a0b0c0d0e0f;
    e_fin = 128'h00050a0f04090e03080d02070c01060b;

    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_mode  = 2'd0;
    bus.i_state = '0;
    bus.i_key   = '0;
    last_exp    = '0;
    #2;
    chk1("reset_valid", bus.o_valid, 1'b0);
    chk128("reset_state", bus.o_state, '0);
    @(negedge clk);
    rst_n = 1'b1;

    step("initial", 1'b1, 2'd0, s_ini, k_ini, e_ini);
    step("middle", 1'b1, 2'd1, s_mid, k_mid, e_mid);
    step("final", 1'b1, 2'd2, s_fin, '0, e_fin);
    step("mode3", 1'b1, 2'd3, s_fin, '0, e_fin);

    step("mc_col0", 1'b1, 2'd1,
         place_col(32'hdb135345, 0), '0,
         out_col(32'h8e4da1bc, 0));
    step("mc_col1", 1'b1, 2'd1,
         place_col(32'hf20a225c, 1), '0,
         out_col(32'h9fdc589d, 1));
    step("mc_col2", 1'b1, 2'd1,
         place_col(32'hd4d4d4d5, 2), '0,
         out_col(32'hd5d5d7d6, 2));
    step("mc_col3", 1'b1, 2'd1,
         place_col(32'hc6c6c6c6, 3), '0,
         out_col(32'hc6c6c6c6, 3));

    step("idle0", 1'b0, 2'd1, s_mid, k_mid, '0);
    step("b2b_ini", 1'b1, 2'd0, s_ini, k_ini, e_ini);
    step("b2b_mid", 1'b1, 2'd1, s_mid, k_mid, e_mid);
    step("b2b_fin", 1'b1, 2'd2, s_fin, '0, e_fin);
    step("idle1", 1'b0, 2'd0, s_ini, k_ini, '0);
    step("idle2", 1'b0, 2'd1, s_mid, '1, '0);

    step("pre_rst", 1'b1, 2'd1, s_mid, k_mid, e_mid);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_valid", bus.o_valid, 1'b0);
    chk128("async_rst_state", bus.o_state, '0);
    last_exp = '0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 2'd0, s_ini, k_ini, e_ini);
    step("post_idle", 1'b0, 2'd0, '0, '0, '0);

    chk1("queue_empty", q.size() == 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
